wave_meter: RTL and testbench

WAVE_METER -- requirements
Module: wave_meter

---
 rtl/wave_meter.sv | 197 +++++++++++++++++++
 tb/tb_wave_meter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_meter.sv
// wave_meter: measures the period and high time of an asynchronous
// waveform in clk cycles. It raises no_signal when no edge arrives for
// TIMEOUT cycles.
//
// Edges are taken from a 2-flop synchronizer (s1, s2) followed by a history
// flop (s3). Every count uses the cycle positions of those synchronized
// edges, so the synchronizer latency cancels out of period and high_time.
module wave_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 25000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wave_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // The timeout counter value seen in the cycle just before TIMEOUT is reached.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_SAT   = CNT_W'(TIMEOUT);

    // Reject a TIMEOUT that the counters cannot represent, or one too short to be useful.
    if (TIMEOUT < 4 || longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
        $error("wave_meter: TIMEOUT outside 4 .. 2**CNT_W-1");
    end

    // Synchronizer, history flop and edge strobes
    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] sync_fill;
    logic       sync_ready;
    logic       rise;
    logic       fall;
    logic       any_edge;

    // Measurement state
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_cap;
    logic [CNT_W-1:0] hi_cap_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;

    // Output next-state values
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_time_nxt;
    logic             meas_valid_nxt;
    logic             no_signal_nxt;

    // Shift wave_in through the synchronizer and history flop.
    // sync_fill records when s2 first holds a real sample instead of a reset zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make s1 -> s2 -> s3 a real
            // shift chain. Blocking assignments would collapse it into one flop.
            s1        <= wave_in;
            s2        <= s1;
            s3        <= s2;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // ARM must not trust s2 until it holds a sampled value. Otherwise a wave
    // that is high out of reset would look like a low followed by a rise.
    assign sync_ready = sync_fill[1];
    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign any_edge   = rise | fall;

    // The timeout fires only when no edge arrives in the same cycle, so an edge always wins.
    assign timeout_hit = ~any_edge & (to_cnt == TO_LAST);

    // Saturating increment keeps cnt from ever wrapping.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Timeout counter: cleared by any edge, otherwise counts up and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= CNT_ZERO;
        end else if (any_edge) begin
            to_cnt <= CNT_ZERO;
        end else if (to_cnt != TO_SAT) begin
            to_cnt <= to_cnt + CNT_ONE;
        end
    end

    // Next-state and next-datapath logic for the measurement FSM.
    always_comb begin
        // NOTE: every target gets a default first. A path through the case
        // that skips an assignment would otherwise infer a latch.
        state_nxt      = state;
        cnt_nxt        = cnt;
        hi_cap_nxt     = hi_cap;
        period_nxt     = period;
        high_time_nxt  = high_time;
        meas_valid_nxt = 1'b0;
        no_signal_nxt  = no_signal;

        if (timeout_hit) begin
            // Drop any partial measurement and start over from ARM.
            // period and high_time keep their last values.
            state_nxt     = ARM;
            cnt_nxt       = CNT_ZERO;
            hi_cap_nxt    = CNT_ZERO;
            no_signal_nxt = 1'b1;
        end else begin
            unique case (state)
                ARM: begin
                    cnt_nxt = CNT_ZERO;
                    if (sync_ready && !s2) begin
                        state_nxt = WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    cnt_nxt = cnt_inc;
                    if (fall) begin
                        hi_cap_nxt = cnt;
                        state_nxt  = LOW;
                    end
                end
                LOW: begin
                    cnt_nxt = cnt_inc;
                    if (rise) begin
                        // Complete the measurement and start the next one on this same rise.
                        period_nxt     = cnt;
                        high_time_nxt  = hi_cap;
                        meas_valid_nxt = 1'b1;
                        no_signal_nxt  = 1'b0;
                        cnt_nxt        = CNT_ONE;
                        state_nxt      = HIGH;
                    end
                end
                default: begin
                    state_nxt = ARM;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARM;
        end else begin
            state <= state_nxt;
        end
    end

    // Running counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= CNT_ZERO;
            hi_cap     <= CNT_ZERO;
            period     <= CNT_ZERO;
            high_time  <= CNT_ZERO;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            hi_cap     <= hi_cap_nxt;
            period     <= period_nxt;
            high_time  <= high_time_nxt;
            meas_valid <= meas_valid_nxt;
            no_signal  <= no_signal_nxt;
        end
    end

endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: self-checking bench for wave_meter.
// A timestamp-based reference model predicts every output on every cycle.
// Table vectors and hand-written sequences cover the corner cases.
module tb_wave_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wave_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             no_signal;

    wave_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wave_in   (wave_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .no_signal (no_signal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mv_seen = 0;

    // Reference model. The synchronized level at edge k is the wave_in
    // sample taken two edges earlier. Measurements are differences between
    // the edge numbers of synchronized rises and falls.
    int               k;
    int               last_edge;
    int               rise_k;
    int               fall_k;
    bit               armed;
    bit               have_rise;
    bit               have_fall;
    bit               smp[$];
    bit               exp_mv;
    bit               exp_ns;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        k          = 0;
        last_edge  = 0;
        armed      = 1'b0;
        have_rise  = 1'b0;
        have_fall  = 1'b0;
        exp_mv     = 1'b0;
        exp_ns     = 1'b1;
        exp_period = '0;
        exp_high   = '0;
        smp.delete();
        repeat (3) smp.push_back(1'b0);
    endtask

    // Predict the outputs that are visible after edge k, where w is the value sampled at edge k.
    task automatic model_step(input bit w);
        bit prev;
        bit cur;
        bit r;
        bit f;
        k++;
        smp.push_back(w);
        prev = smp.pop_front();   // sample from edge k-3
        cur  = smp[0];            // sample from edge k-2
        r    = cur & ~prev;
        f    = ~cur & prev;
        exp_mv = 1'b0;
        if (r || f) begin
            last_edge = k;
        end else if (k - last_edge == TIMEOUT) begin
            exp_ns    = 1'b1;
            armed     = 1'b0;
            have_rise = 1'b0;
            have_fall = 1'b0;
            return;
        end
        if (!armed) begin
            // The level only reflects wave_in from the third edge after reset onwards.
            if (k >= 3 && !cur) armed = 1'b1;
        end else if (!have_rise) begin
            if (r) begin
                have_rise = 1'b1;
                rise_k    = k;
            end
        end else if (!have_fall) begin
            if (f) begin
                have_fall = 1'b1;
                fall_k    = k;
            end
        end else if (r) begin
            exp_period = CNT_W'(k - rise_k);
            exp_high   = CNT_W'(fall_k - rise_k);
            exp_mv     = 1'b1;
            exp_ns     = 1'b0;
            rise_k     = k;
            have_fall  = 1'b0;
        end
    endtask

    // Run one clock: drive wave_in, advance the model at the rising edge,
    // then compare all outputs at the falling edge.
    task automatic tick(input bit w);
        wave_in = w;
        @(posedge clk);
        model_step(w);
        @(negedge clk);
        if (meas_valid === 1'b1) mv_seen++;
        check($sformatf("model_cycle_%0d", k),
              64'({meas_valid, no_signal, period, high_time}),
              64'({exp_mv, exp_ns, exp_period, exp_high}));
    endtask

    task automatic drive_wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    // Assert reset away from any clock edge, check the asynchronous effect,
    // and release it on a falling edge.
    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_period"},  64'(period),     64'(0));
        check({tag, "_high"},    64'(high_time),  64'(0));
        check({tag, "_valid"},   64'(meas_valid), 64'(0));
        check({tag, "_nosig"},   64'(no_signal),  64'(1));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int mv0;
        int first_at;
        int hi;
        int lo;

        vecs[0] = '{hi: 10, lo: 15,   reps: 4, exp_period: 25,   exp_high: 10};
        vecs[1] = '{hi: 1,  lo: 1,    reps: 6, exp_period: 2,    exp_high: 1};
        vecs[2] = '{hi: 20, lo: 30,   reps: 3, exp_period: 50,   exp_high: 20};
        vecs[3] = '{hi: 40, lo: 10,   reps: 3, exp_period: 50,   exp_high: 40};
        vecs[4] = '{hi: 5,  lo: 5,    reps: 4, exp_period: 10,   exp_high: 5};
        vecs[5] = '{hi: 3,  lo: 7,    reps: 3, exp_period: 10,   exp_high: 3};
        // The low time equals TIMEOUT, so the rise and the timeout land on the same cycle and the rise wins.
        vecs[6] = '{hi: 5,  lo: 1000, reps: 3, exp_period: 1005, exp_high: 5};

        reset_n = 1'b1;
        wave_in = 1'b0;
        pulse_reset("por");

        // Table-driven steady waveforms
        for (int i = 0; i < NV; i++) begin
            drive_wave(vecs[i].hi, vecs[i].lo, vecs[i].reps);
            check($sformatf("vec%0d_period", i), 64'(period),    64'(vecs[i].exp_period));
            check($sformatf("vec%0d_high", i),   64'(high_time), 64'(vecs[i].exp_high));
            check($sformatf("vec%0d_nosig", i),  64'(no_signal), 64'(0));
        end

        // Latency: the first high sample of wave_in produces meas_valid two edges later.
        drive_wave(5, 5, 3);
        first_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1);
            if (meas_valid === 1'b1 && first_at == 0) first_at = i;
        end
        check("rise_to_valid_ticks", 64'(first_at), 64'(3));
        repeat (5) tick(1'b0);

        // Timeout: no_signal rises TIMEOUT cycles after the synchronized
        // fall, and the measurement registers hold.
        drive_wave(10, 15, 3);
        repeat (10) tick(1'b1);
        mv0      = mv_seen;
        first_at = 0;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            tick(1'b0);
            if (no_signal === 1'b1 && first_at == 0) first_at = n;
        end
        check("timeout_ticks",    64'(first_at),      64'(TIMEOUT + 3));
        check("timeout_no_valid", 64'(mv_seen - mv0), 64'(0));
        check("timeout_period",   64'(period),        64'(25));
        check("timeout_high",     64'(high_time),     64'(10));
        drive_wave(10, 15, 1);
        check("resume_still_nosig", 64'(no_signal), 64'(1));
        drive_wave(10, 15, 2);
        check("resume_nosig",  64'(no_signal), 64'(0));
        check("resume_period", 64'(period),    64'(25));

        // Wave held high through reset release, then 5/5: no early measurement.
        @(negedge clk);
        wave_in = 1'b1;
        pulse_reset("rst_high");
        mv0 = mv_seen;
        repeat (50) tick(1'b1);
        repeat (5) tick(1'b0);
        repeat (5) tick(1'b1);
        repeat (5) tick(1'b0);
        check("arm_high_no_early_valid", 64'(mv_seen - mv0), 64'(0));
        repeat (5) tick(1'b1);
        check("arm_high_one_valid", 64'(mv_seen - mv0), 64'(1));
        check("arm_high_period",    64'(period),        64'(10));
        check("arm_high_high",      64'(high_time),     64'(5));
        repeat (5) tick(1'b0);

        // Reset pulsed during a high phase abandons the measurement in progress.
        drive_wave(10, 15, 3);
        repeat (4) tick(1'b1);
        pulse_reset("rst_mid");
        mv0 = mv_seen;
        repeat (6) tick(1'b1);
        repeat (15) tick(1'b0);
        repeat (10) tick(1'b1);
        repeat (15) tick(1'b0);
        check("rst_mid_no_early_valid", 64'(mv_seen - mv0), 64'(0));
        repeat (10) tick(1'b1);
        check("rst_mid_one_valid", 64'(mv_seen - mv0), 64'(1));
        check("rst_mid_period",    64'(period),        64'(25));
        check("rst_mid_high",      64'(high_time),     64'(10));
        repeat (15) tick(1'b0);

        // Random segments, some with low times around TIMEOUT.
        for (int s = 0; s < 40; s++) begin
            hi = int'($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(995, 1005));
            else                           lo = int'($urandom_range(1, 40));
            drive_wave(hi, lo, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
